// File: rtl/mpc_flow_control_loop_pipe_sequential_init_if.sv
// Handshake bundle between the parent controller, this flow-control block and
// the pipelined loop body.
interface mpc_flow_control_loop_pipe_sequential_init_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_start_int;
  logic ap_loop_init;
  logic ap_ready_int;
  logic ap_loop_exit_ready;
  logic ap_loop_exit_done;
  logic ap_continue_int;
  logic ap_done_int;

  // master drives requests and loop-status inputs into the block
  modport master (
    output ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
    input  ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int
  );

  modport slave (
    input  ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
    output ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int
  );
endinterface

// File: rtl/mpc_flow_control_loop_pipe_sequential_init.sv
// Sequential-init flow control around a pipelined loop: first-iteration marker
// and sticky done, both tracked by one flop each.
module mpc_flow_control_loop_pipe_sequential_init (
  input  logic ap_clk,
  input  logic ap_rst,
  mpc_flow_control_loop_pipe_sequential_init_if.slave bus
);

  logic loop_init_int;
  logic done_cache;
  logic unused_done_int;

  assign unused_done_int = bus.ap_done_int;

  // exit wins over an iteration accept, so a new run always starts with init
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      loop_init_int <= 1'b1;
    end else if (bus.ap_loop_exit_done) begin
      loop_init_int <= 1'b1;
    end else if (bus.ap_ready_int) begin
      loop_init_int <= 1'b0;
    end
  end

  // a new start wins over exit; done is still shown combinationally that cycle
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      done_cache <= 1'b0;
    end else if (bus.ap_start) begin
      done_cache <= 1'b0;
    end else if (bus.ap_loop_exit_done) begin
      done_cache <= 1'b1;
    end
  end

  assign bus.ap_start_int    = bus.ap_start;
  assign bus.ap_continue_int = 1'b1;
  assign bus.ap_ready        = bus.ap_loop_exit_ready;
  assign bus.ap_loop_init    = loop_init_int & bus.ap_start;
  assign bus.ap_done         = bus.ap_loop_exit_done | done_cache;

endmodule

// File: tb/tb_mpc_flow_control_loop_pipe_sequential_init.sv
// Directed checks of the loop flow-control block with hand-computed expectations.
module tb_mpc_flow_control_loop_pipe_sequential_init;

  logic ap_clk;
  logic ap_rst;
  int   total;
  int   bad;

  mpc_flow_control_loop_pipe_sequential_init_if bus();

  mpc_flow_control_loop_pipe_sequential_init dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // move to 2 time units after the next rising edge, away from both edges
  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ap_rst                 = 1'b1;
    bus.ap_start           = 1'b0;
    bus.ap_ready_int       = 1'b0;
    bus.ap_loop_exit_ready = 1'b0;
    bus.ap_loop_exit_done  = 1'b0;
    bus.ap_done_int        = 1'b0;
    #3;

    // outputs while held in reset
    chk("rst_done", bus.ap_done, 1'b0);
    chk("rst_init_nostart", bus.ap_loop_init, 1'b0);
    chk("rst_cont", bus.ap_continue_int, 1'b1);
    bus.ap_start = 1'b1;
    #1;
    chk("rst_init_start", bus.ap_loop_init, 1'b1);
    chk("rst_start_int", bus.ap_start_int, 1'b1);
    bus.ap_loop_exit_done  = 1'b1;
    bus.ap_loop_exit_ready = 1'b1;
    #1;
    chk("rst_done_follow", bus.ap_done, 1'b1);
    chk("rst_ready_follow", bus.ap_ready, 1'b1);
    bus.ap_loop_exit_done  = 1'b0;
    bus.ap_loop_exit_ready = 1'b0;
    bus.ap_start           = 1'b0;
    tick();
    ap_rst = 1'b0;
    #1;

    // first iteration after reset
    bus.ap_start = 1'b1;
    #1;
    chk("run_init", bus.ap_loop_init, 1'b1);
    chk("run_start_int", bus.ap_start_int, 1'b1);
    chk("run_done", bus.ap_done, 1'b0);
    chk("run_cont", bus.ap_continue_int, 1'b1);
    tick();
    chk("run_init_hold", bus.ap_loop_init, 1'b1);

    // one accepted iteration clears init from the next cycle on
    bus.ap_ready_int = 1'b1;
    bus.ap_done_int  = 1'b1;
    #1;
    chk("acc_init_same", bus.ap_loop_init, 1'b1);
    tick();
    bus.ap_ready_int = 1'b0;
    #1;
    chk("acc_init_next", bus.ap_loop_init, 1'b0);
    tick();
    chk("acc_init_later", bus.ap_loop_init, 1'b0);

    // exit_ready is a pure combinational pass-through
    bus.ap_loop_exit_ready = 1'b1;
    #1;
    chk("xr_ready", bus.ap_ready, 1'b1);
    chk("xr_done", bus.ap_done, 1'b0);
    tick();
    bus.ap_loop_exit_ready = 1'b0;
    #1;
    chk("xr_ready_off", bus.ap_ready, 1'b0);
    chk("xr_done_after", bus.ap_done, 1'b0);

    // sticky done with start low
    bus.ap_start = 1'b0;
    bus.ap_done_int = 1'b0;
    bus.ap_loop_exit_done = 1'b1;
    #1;
    chk("sd_pulse", bus.ap_done, 1'b1);
    tick();
    bus.ap_loop_exit_done = 1'b0;
    #1;
    chk("sd_hold1", bus.ap_done, 1'b1);
    chk("sd_init_nostart", bus.ap_loop_init, 1'b0);
    tick();
    chk("sd_hold2", bus.ap_done, 1'b1);
    bus.ap_start = 1'b1;
    #1;
    chk("sd_start_same", bus.ap_done, 1'b1);
    chk("b2b_init", bus.ap_loop_init, 1'b1);
    tick();
    chk("sd_cleared", bus.ap_done, 1'b0);
    chk("b2b_init_hold", bus.ap_loop_init, 1'b1);

    // start and exit_done together: done shown now, cache not set
    bus.ap_loop_exit_done = 1'b1;
    #1;
    chk("se_done_same", bus.ap_done, 1'b1);
    tick();
    bus.ap_loop_exit_done = 1'b0;
    #1;
    chk("se_done_next", bus.ap_done, 1'b0);

    // clear init, then exit_done with ready_int: exit wins
    bus.ap_ready_int = 1'b1;
    tick();
    bus.ap_ready_int = 1'b0;
    #1;
    chk("ex_pre_init", bus.ap_loop_init, 1'b0);
    bus.ap_start = 1'b0;
    bus.ap_loop_exit_done = 1'b1;
    bus.ap_ready_int = 1'b1;
    tick();
    bus.ap_loop_exit_done = 1'b0;
    bus.ap_ready_int = 1'b0;
    bus.ap_start = 1'b1;
    #1;
    chk("ex_init_wins", bus.ap_loop_init, 1'b1);
    chk("ex_done_cache", bus.ap_done, 1'b1);
    tick();
    chk("ex_done_clr", bus.ap_done, 1'b0);

    // async reset mid-loop with done cached and init cleared
    bus.ap_start = 1'b0;
    bus.ap_loop_exit_done = 1'b1;
    tick();
    bus.ap_loop_exit_done = 1'b0;
    bus.ap_ready_int = 1'b1;
    tick();
    bus.ap_ready_int = 1'b0;
    bus.ap_start = 1'b1;
    #1;
    chk("ar_pre_done", bus.ap_done, 1'b1);
    chk("ar_pre_init", bus.ap_loop_init, 1'b0);
    bus.ap_start = 1'b0;
    #1;
    ap_rst = 1'b1;
    #1;
    chk("ar_done_drop", bus.ap_done, 1'b0);
    bus.ap_start = 1'b1;
    #1;
    chk("ar_init_now", bus.ap_loop_init, 1'b1);
    ap_rst = 1'b0;
    tick();
    chk("ar_init_after", bus.ap_loop_init, 1'b1);
    chk("ar_done_after", bus.ap_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpc_flow_control_loop_pipe_sequential_init.md
MPC_FLOW_CONTROL_LOOP_PIPE_SEQUENTIAL_INIT -- requirements
Module: mpc_flow_control_loop_pipe_sequential_init

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no parameters.
REQ-002 ap_clk  input  1  clock; all state updates on the rising edge.
REQ-003 ap_rst  input  1  asynchronous active-high reset.
REQ-004 ap_start  input  1  start request from the parent.
REQ-005 ap_ready  output  1  ready to the parent; the loop accepted its last iteration.
REQ-006 ap_done  output  1  done to the parent.
REQ-007 ap_start_int  output  1  internal start to the pipelined loop body.
REQ-008 ap_loop_init  output  1  first-iteration marker; the loop body resets its induction variables.
REQ-009 ap_ready_int  input  1  loop body accepted an iteration this cycle.
REQ-010 ap_loop_exit_ready  input  1  exit condition, stage 0: last iteration issued.
REQ-011 ap_loop_exit_done  input  1  pipeline drained; loop complete.
REQ-012 ap_continue_int  output  1  internal continue to the loop body.
REQ-013 ap_done_int  input  1  loop body's done indication; accepted and not used by the logic.

Function
REQ-014 The block SHALL hold exactly two state flops: loop_init_int and done_cache; all else combinational.
REQ-015 ap_start_int SHALL equal ap_start, combinationally, zero latency.
REQ-016 ap_continue_int SHALL be constant 1.
REQ-017 ap_ready SHALL equal ap_loop_exit_ready, combinationally.
REQ-018 loop_init_int update priority per edge: ap_loop_exit_done=1 -> 1; else ap_ready_int=1 -> 0; else hold.
REQ-019 ap_loop_init SHALL equal loop_init_int AND ap_start.
REQ-020 done_cache update priority per edge: ap_start=1 -> 0; else ap_loop_exit_done=1 -> 1; else hold.
REQ-021 ap_done SHALL equal ap_loop_exit_done OR done_cache, so done is visible in the exit cycle and stays sticky until the next ap_start.
REQ-022 Simultaneous ap_loop_exit_done and ap_ready_int SHALL set loop_init_int to 1, since exit wins.
REQ-023 Simultaneous ap_start and ap_loop_exit_done SHALL clear done_cache, since start wins; ap_done is still 1 that cycle via the combinational path.
REQ-024 With ap_start=0, ap_loop_init SHALL be 0 regardless of loop_init_int; loop_init_int is not modified by ap_start.
REQ-025 Back-to-back invocations: after ap_loop_exit_done, the next cycle with ap_start=1 SHALL present ap_loop_init=1 until the first ap_ready_int.

Reset
REQ-026 On ap_rst=1, asynchronously: loop_init_int=1, done_cache=0.
REQ-027 Outputs during reset: ap_done = ap_loop_exit_done; ap_loop_init = ap_start; ap_ready = ap_loop_exit_ready; ap_start_int = ap_start; ap_continue_int = 1.
REQ-028 Reset asserted mid-loop SHALL abort state immediately, without waiting for a clock edge; the next ap_start SHALL begin a fresh run with ap_loop_init=1.

Verification
REQ-029 Reset then ap_start=1, ap_ready_int=0 -> ap_loop_init=1, ap_start_int=1, ap_done=0, ap_continue_int=1.
REQ-030 ap_start=1, ap_ready_int pulsed 1 cycle -> ap_loop_init=0 from the next cycle onward, while ap_start stays 1.
REQ-031 ap_loop_exit_ready=1 for one cycle -> ap_ready=1 in the same cycle only; done_cache unaffected.
REQ-032 ap_start=0 and ap_loop_exit_done pulsed -> ap_done=1 in the pulse cycle and every following cycle; the next ap_start=1 -> ap_done=0 the cycle after.
REQ-033 Same-cycle ap_loop_exit_done=1 and ap_ready_int=1 -> the next cycle with ap_start=1 shows ap_loop_init=1.
REQ-034 ap_rst asserted between clock edges while done_cache=1 -> ap_done drops to 0 immediately (ap_loop_exit_done=0); the following ap_start gives ap_loop_init=1.
